// File: rtl/apb_arb_master.sv
// Two-requester APB master: round-robin arbitration in front of a single
// IDLE/SETUP/ACCESS APB transfer engine with a bounded ACCESS phase.
module apb_arb_master #(
  parameter int ADDR_WIDTH = 8,
  parameter int WIDTH      = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                    pclk_i,
  input  logic                    presetn_i,
  input  logic [1:0]              req_i,
  input  logic [1:0]              req_write_i,
  input  logic [2*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [2*WIDTH-1:0]      req_wdata_i,
  output logic [1:0]              done_o,
  output logic [WIDTH-1:0]        rdata_o,
  output logic                    slverr_o,
  output logic                    psel_o,
  output logic                    penable_o,
  output logic                    pwrite_o,
  output logic [ADDR_WIDTH-1:0]   paddr_o,
  output logic [WIDTH-1:0]        pwdata_o,
  input  logic [WIDTH-1:0]        prdata_i,
  input  logic                    pready_i,
  input  logic                    pslverr_i
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  localparam logic [7:0] TLAST = 8'(TIMEOUT - 1);

  state_t                  state, state_nxt;
  logic                    last, last_nxt;
  logic                    gnt, gnt_nxt;
  logic                    pick;
  logic [7:0]              tcnt, tcnt_nxt;
  logic [1:0]              done_nxt;
  logic [WIDTH-1:0]        rdata_nxt, pwdata_nxt;
  logic                    slverr_nxt, psel_nxt, penable_nxt, pwrite_nxt;
  logic [ADDR_WIDTH-1:0]   paddr_nxt;

  // 'last' holds the index granted most recently; on contention the other side wins.
  assign pick = (&req_i) ? ~last : req_i[1];

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_nxt   = state;
    last_nxt    = last;
    gnt_nxt     = gnt;
    tcnt_nxt    = tcnt;
    psel_nxt    = psel_o;
    penable_nxt = penable_o;
    pwrite_nxt  = pwrite_o;
    paddr_nxt   = paddr_o;
    pwdata_nxt  = pwdata_o;
    done_nxt    = 2'b00;
    rdata_nxt   = '0;
    slverr_nxt  = 1'b0;

    case (state)
      IDLE: begin
        if (|req_i) begin
          gnt_nxt     = pick;
          last_nxt    = pick;
          pwrite_nxt  = req_write_i[pick];
          paddr_nxt   = pick ? req_addr_i[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr_i[ADDR_WIDTH-1:0];
          pwdata_nxt  = pick ? req_wdata_i[2*WIDTH-1:WIDTH] : req_wdata_i[WIDTH-1:0];
          psel_nxt    = 1'b1;
          penable_nxt = 1'b0;
          state_nxt   = SETUP;
        end
      end
      SETUP: begin
        penable_nxt = 1'b1;
        tcnt_nxt    = '0;
        state_nxt   = ACCESS;
      end
      ACCESS: begin
        if (pready_i || tcnt == TLAST) begin
          done_nxt    = gnt ? 2'b10 : 2'b01;
          psel_nxt    = 1'b0;
          penable_nxt = 1'b0;
          state_nxt   = IDLE;
          // A late pready still wins over the timeout on the same edge.
          if (pready_i) begin
            rdata_nxt  = pwrite_o ? '0 : prdata_i;
            slverr_nxt = pslverr_i;
          end else begin
            slverr_nxt = 1'b1;
          end
        end else begin
          tcnt_nxt = tcnt + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so all of them update
  // together from values sampled before the edge.
  always_ff @(posedge pclk_i or negedge presetn_i) begin
    if (!presetn_i) begin
      state     <= IDLE;
      last      <= 1'b1;
      gnt       <= 1'b0;
      tcnt      <= '0;
      psel_o    <= 1'b0;
      penable_o <= 1'b0;
      pwrite_o  <= 1'b0;
      paddr_o   <= '0;
      pwdata_o  <= '0;
      done_o    <= 2'b00;
      rdata_o   <= '0;
      slverr_o  <= 1'b0;
    end else begin
      state     <= state_nxt;
      last      <= last_nxt;
      gnt       <= gnt_nxt;
      tcnt      <= tcnt_nxt;
      psel_o    <= psel_nxt;
      penable_o <= penable_nxt;
      pwrite_o  <= pwrite_nxt;
      paddr_o   <= paddr_nxt;
      pwdata_o  <= pwdata_nxt;
      done_o    <= done_nxt;
      rdata_o   <= rdata_nxt;
      slverr_o  <= slverr_nxt;
    end
  end

endmodule

// File: doc/apb_arb_master.md
APB_ARB_MASTER -- requirements
Module: apb_arb_master

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, default 8, APB address width; WIDTH, default 32, APB data width; TIMEOUT, default 16, maximum ACCESS cycles before forced termination (range 2..255).
REQ-002 Ports SHALL be, one per line:
  pclk_i  in  1  APB clock; all state updates on posedge
  presetn_i  in  1  reset, asynchronous, active-low
  req_i  in  2  per-requester transfer request, level, held until matching done_o
  req_write_i  in  2  per-requester direction (1 = write)
  req_addr_i  in  2*ADDR_WIDTH  per-requester address; requester k uses slice k
  req_wdata_i  in  2*WIDTH  per-requester write data; requester k uses slice k
  done_o  out  2  one-cycle completion pulse for requester k
  rdata_o  out  WIDTH  read data, valid while any done_o bit is high
  slverr_o  out  1  error status, valid while any done_o bit is high
  psel_o  out  1  APB select
  penable_o  out  1  APB enable
  pwrite_o  out  1  APB direction
  paddr_o  out  ADDR_WIDTH  APB address
  pwdata_o  out  WIDTH  APB write data
  prdata_i  in  WIDTH  APB read data from slave
  pready_i  in  1  APB ready from slave
  pslverr_i  in  1  APB error from slave
REQ-003 The clock SHALL be pclk_i; the reset SHALL be presetn_i, asynchronous and active-low.

Function
REQ-004 FSM states SHALL be IDLE, SETUP and ACCESS.
REQ-005 All outputs SHALL be registered.
REQ-006 In IDLE with any req_i bit high at a posedge, the block SHALL grant one requester k.
  - It SHALL capture that requester's write, address and wdata slices into pwrite_o, paddr_o and pwdata_o.
  - It SHALL set psel_o=1 and penable_o=0, and enter SETUP.
REQ-007 SETUP SHALL last exactly one cycle, then set penable_o=1 and enter ACCESS.
REQ-008 In ACCESS with pready_i=1 at a posedge, the block SHALL complete the transfer:
  - done_o[k]=1 for one cycle.
  - rdata_o = prdata_i for reads, 0 for writes.
  - slverr_o = pslverr_i.
  - psel_o=0, penable_o=0, return to IDLE.
REQ-009 Minimum latency SHALL be 3 cycles from the req_i sample edge to done_o high.
REQ-010 Back-to-back transfers SHALL have at least one IDLE cycle (psel_o=0) between transfers.
REQ-011 Arbitration SHALL be round-robin with a 1-bit last-grant pointer:
  - On a simultaneous request, the requester not granted last wins.
  - A single requester always wins.
  - The pointer updates only on grant.
REQ-012 paddr_o, pwrite_o and pwdata_o SHALL stay stable from SETUP until completion, independent of req_* changes.
REQ-013 A requester dropping req_i after grant SHALL NOT abort the transfer; its done_o still pulses.
REQ-014 A TIMEOUT counter SHALL run as follows:
  - It clears on entering ACCESS and increments each ACCESS cycle without pready_i.
  - On the TIMEOUT-th ACCESS cycle without pready_i, the block SHALL terminate the transfer as in REQ-008 but with slverr_o=1 and rdata_o=0.
  - pready_i on that same edge SHALL take priority over the timeout (normal completion).
REQ-015 done_o, rdata_o and slverr_o SHALL be 0 in every cycle without completion; done_o SHALL never have both bits set.
REQ-016 pslverr_i and prdata_i SHALL be ignored outside ACCESS.

Reset
REQ-017 presetn_i low SHALL immediately force:
  - state to IDLE.
  - psel_o, penable_o, pwrite_o, done_o, slverr_o to 0.
  - paddr_o, pwdata_o, rdata_o to 0.
  - pointer favouring requester 0, timeout counter to 0.
REQ-018 A reset during SETUP or ACCESS SHALL abandon the transfer with no done_o pulse.
REQ-019 After reset release, the first grant SHALL occur no earlier than the first posedge with presetn_i high.

Verification
REQ-020 Single write: req_i=01, addr 0x10, wdata 0xDEADBEEF, pready_i=1 → SETUP then ACCESS; done_o=01 on cycle 3; slverr_o=0; rdata_o=0.
REQ-021 Read with 2 wait states: req_i=10, addr 0x24, prdata_i=0x12345678 on the ready cycle → done_o=10 on cycle 5; rdata_o=0x12345678.
REQ-022 Contention after reset: req_i=11 held → grants in order 0,1,0,1; each transfer separated by an IDLE cycle; no done_o overlap.
REQ-023 Timeout: TIMEOUT=16, pready_i held 0 → after 16 ACCESS cycles done_o pulses with slverr_o=1 and rdata_o=0; psel_o drops.
REQ-024 Slave error: pready_i=1 with pslverr_i=1 on a read → slverr_o=1 with done_o.
REQ-025 Reset mid-ACCESS: presetn_i low for 2 cycles → outputs 0 asynchronously; no done_o; next request served with requester 0 priority.
